fetch_seq: RTL and testbench

Front-end fetch sequencer: owns the fetch PC and drives the I-cache request/response channel with at most one request outstanding. It presents each accepted response to predecode, advances the PC by predecode's `pc_inc_amount`, and handles flush redirects, including discarding a response that was in flight when the flush arrived. It sits between the backend flush source, the I-cache port and `predecode`.

---
 rtl/com_pkg.sv | 27 ++
 rtl/fetch_seq_perf.sv | 23 ++
 rtl/fetch_seq.sv | 140 ++++++++++++++
 tb/tb_fetch_seq.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/com_pkg.sv
// Shared types for the fetch front end: flush redirect bundle, fetch FSM
// state encoding, and the predecode byte-advance clamp.
package com_pkg;

  localparam int COM_XLEN    = 32;
  localparam int FETCH_BYTES = 16;

  typedef struct packed {
    logic                valid;
    logic [COM_XLEN-1:0] pc;
  } flush_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_seq_state_e;

  // Predecode advances are halfword granular, so bit 0 is dropped.
  // Anything beyond one fetch block is clamped to the block size.
  function automatic logic [4:0] fetch_inc(input logic [4:0] amt);
    logic [4:0] even;
    even = {amt[4:1], 1'b0};
    return (even > 5'(FETCH_BYTES)) ? 5'(FETCH_BYTES) : even;
  endfunction

endpackage

// File: rtl/fetch_seq_perf.sv
// Fetch performance counters: cycles lost to downstream stall with a live
// response waiting, and number of flush redirects. Both wrap at 2^32.
module fetch_seq_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_evt,
  input  logic        flush_evt,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  // Event counters; events arrive already qualified by clk_en.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_evt) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_evt) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the fetch PC, keeps at most one I-cache request in
// flight, hands accepted responses to predecode and handles flush redirects,
// discarding a response that was already in flight when the flush landed.
// Optional perf counters are built when FETCH_SEQ_PERF_EN is defined.
//
// state | meaning
// IDLE  | out of reset, nothing issued yet
// REQ   | request presented at pc, waiting for ic_req_ready
// WAIT  | request accepted, waiting for the response handshake
module fetch_seq
  import com_pkg::*;
#(
  parameter int              XLEN     = COM_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clk_en,
  input  flush_t          flush,
  input  logic            stall,
  output logic            ic_req_valid,
  input  logic            ic_req_ready,
  output logic [XLEN-1:0] ic_req_addr,
  input  logic            ic_rsp_valid,
  output logic            ic_rsp_ready,
  output logic            pd_valid,
  output logic [XLEN-1:0] pd_pc,
  input  logic [4:0]      pc_inc_amount,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
);

  fetch_seq_state_e state, state_n;
  logic [XLEN-1:0]  pc, pc_n;
  logic             drop, drop_n;

  logic             req_hs;
  logic             rsp_hs;
  logic [XLEN-1:0]  flush_target;
  logic [XLEN-1:0]  inc_ext;
  logic             unused_flush_lsb;

  // Flush targets are forced halfword aligned.
  assign flush_target     = {flush.pc[XLEN-1:1], 1'b0};
  assign unused_flush_lsb = flush.pc[0];
  assign inc_ext          = {{(XLEN-5){1'b0}}, fetch_inc(pc_inc_amount)};

  // Handshake outputs; everything is silenced while clk_en is low.
  always_comb begin
    ic_req_valid = clk_en && (state == REQ);
    ic_rsp_ready = clk_en && (state == WAIT) && (drop || !stall);
    pd_valid     = clk_en && (state == WAIT) && ic_rsp_valid && !drop
                   && !stall && !flush.valid;
    ic_req_addr  = pc;
    pd_pc        = pc;
    req_hs       = ic_req_valid && ic_req_ready;
    rsp_hs       = ic_rsp_valid && ic_rsp_ready;
  end

  // Next state, PC and drop flag; flush overrides every other update.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    drop_n  = drop;
    if (clk_en) begin
      if (flush.valid) begin
        pc_n = flush_target;
        case (state)
          IDLE: state_n = REQ;
          REQ: begin
            if (req_hs) begin
              // The old-address request just went out; its reply is stale.
              state_n = WAIT;
              drop_n  = 1'b1;
            end
          end
          WAIT: begin
            if (rsp_hs) begin
              // The reply is consumed this cycle and discarded (pd_valid=0).
              state_n = REQ;
              drop_n  = 1'b0;
            end else begin
              drop_n = 1'b1;
            end
          end
          default: state_n = IDLE;
        endcase
      end else begin
        case (state)
          IDLE: state_n = REQ;
          REQ: begin
            if (req_hs) state_n = WAIT;
          end
          WAIT: begin
            if (rsp_hs) begin
              state_n = REQ;
              drop_n  = 1'b0;
            end
          end
          default: state_n = IDLE;
        endcase
        if (pd_valid) pc_n = pc + inc_ext;
      end
    end
  end

  // State register; clk_en low simply re-loads current values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
      drop  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      drop  <= drop_n;
    end
  end

`ifdef FETCH_SEQ_PERF_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = clk_en && (state == WAIT) && ic_rsp_valid && stall && !drop;
  assign flush_evt = clk_en && flush.valid;

  fetch_seq_perf u_perf (
    .clk            (clk),
    .rst            (rst),
    .stall_evt      (stall_evt),
    .flush_evt      (flush_evt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: expected request addresses are queued as
// stimulus is driven and popped when the DUT issues each request.
module tb_fetch_seq;
  import com_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  flush_t      flush;
  logic        stall;
  logic        ic_req_valid;
  logic        ic_req_ready;
  logic [31:0] ic_req_addr;
  logic        ic_rsp_valid;
  logic        ic_rsp_ready;
  logic        pd_valid;
  logic [31:0] pd_pc;
  logic [4:0]  pc_inc_amount;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;

  int          checks   = 0;
  int          failures = 0;
  int          exp_stall = 0;
  int          exp_flush = 0;
  logic [31:0] exp_q[$];

  fetch_seq #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .flush          (flush),
    .stall          (stall),
    .ic_req_valid   (ic_req_valid),
    .ic_req_ready   (ic_req_ready),
    .ic_req_addr    (ic_req_addr),
    .ic_rsp_valid   (ic_rsp_valid),
    .ic_rsp_ready   (ic_rsp_ready),
    .pd_valid       (pd_valid),
    .pd_pc          (pd_pc),
    .pc_inc_amount  (pc_inc_amount),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Request must be up this cycle, at the next address in the scoreboard.
  task automatic check_req(input string tag);
    logic [31:0] e;
    chk({tag, "_valid"}, {31'd0, ic_req_valid}, 32'd1);
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_addr"}, ic_req_addr, e);
    end
  endtask

  initial begin
    rst           = 1'b0;
    clk_en        = 1'b1;
    flush         = '0;
    stall         = 1'b0;
    ic_req_ready  = 1'b1;
    ic_rsp_valid  = 1'b0;
    pc_inc_amount = 5'd0;
    #12;
    chk("rst_req_valid", {31'd0, ic_req_valid}, 32'd0);
    chk("rst_rsp_ready", {31'd0, ic_rsp_ready}, 32'd0);
    chk("rst_pd_valid",  {31'd0, pd_valid}, 32'd0);
    chk("rst_addr",      ic_req_addr, RST_PC);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
    chk("rst_perf_flush", perf_flush_cnt, 32'd0);

    // Release: cycle 0 idle, cycle 1 requests RESET_PC.
    rst = 1'b1;
    exp_q.push_back(RST_PC);
    settle();
    chk("cyc0_req_valid", {31'd0, ic_req_valid}, 32'd0);
    step();
    check_req("req0");
    step();
    chk("wait_rsp_ready", {31'd0, ic_rsp_ready}, 32'd1);
    chk("wait_pd_valid",  {31'd0, pd_valid}, 32'd0);
    step();
    step();

    // Response three cycles after the request, advance 6.
    ic_rsp_valid  = 1'b1;
    pc_inc_amount = 5'd6;
    exp_q.push_back(32'h8000_0006);
    settle();
    chk("rsp1_pd_valid", {31'd0, pd_valid}, 32'd1);
    chk("rsp1_pd_pc",    pd_pc, 32'h8000_0000);
    step();
    ic_rsp_valid = 1'b0;
    settle();
    check_req("req1");
    step();

    // Four stall cycles with the response held.
    ic_rsp_valid  = 1'b1;
    stall         = 1'b1;
    pc_inc_amount = 5'd4;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("stall_rsp_ready", {31'd0, ic_rsp_ready}, 32'd0);
      chk("stall_pd_pc",     pd_pc, 32'h8000_0006);
      exp_stall++;
      step();
    end
    stall = 1'b0;
    exp_q.push_back(32'h8000_000A);
    settle();
    chk("unstall_rsp_ready", {31'd0, ic_rsp_ready}, 32'd1);
    chk("unstall_pd_valid",  {31'd0, pd_valid}, 32'd1);
    step();
    ic_rsp_valid = 1'b0;
    settle();
    check_req("req2");
    step();

    // Flush while waiting; the late response is dropped.
    flush.valid = 1'b1;
    flush.pc    = 32'h0000_0100;
    exp_flush++;
    step();
    flush = '0;
    settle();
    chk("fl_wait_pd_pc", pd_pc, 32'h0000_0100);
    step();
    ic_rsp_valid  = 1'b1;
    pc_inc_amount = 5'd6;
    exp_q.push_back(32'h0000_0100);
    settle();
    chk("fl_wait_rsp_ready", {31'd0, ic_rsp_ready}, 32'd1);
    chk("fl_wait_pd_valid",  {31'd0, pd_valid}, 32'd0);
    step();
    ic_rsp_valid = 1'b0;
    settle();
    check_req("req_fl_wait");
    step();

    // Normal reply +2 to reach a request at 0x102.
    ic_rsp_valid  = 1'b1;
    pc_inc_amount = 5'd2;
    exp_q.push_back(32'h0000_0102);
    settle();
    chk("rsp_102_pd_valid", {31'd0, pd_valid}, 32'd1);
    step();
    ic_rsp_valid = 1'b0;

    // Flush coincident with the request handshake.
    flush.valid = 1'b1;
    flush.pc    = 32'h0000_0100;
    exp_flush++;
    settle();
    check_req("req_fl_hs");
    step();
    flush = '0;
    ic_rsp_valid = 1'b1;
    stall        = 1'b1;
    exp_q.push_back(32'h0000_0100);
    settle();
    chk("fl_hs_rsp_ready", {31'd0, ic_rsp_ready}, 32'd1);
    chk("fl_hs_pd_valid",  {31'd0, pd_valid}, 32'd0);
    step();
    ic_rsp_valid = 1'b0;
    stall        = 1'b0;
    settle();
    check_req("req_fl_hs2");
    step();

    // Move to 0x108, then flush coincident with the response accept.
    ic_rsp_valid  = 1'b1;
    pc_inc_amount = 5'd8;
    exp_q.push_back(32'h0000_0108);
    step();
    ic_rsp_valid = 1'b0;
    settle();
    check_req("req_108");
    step();
    ic_rsp_valid = 1'b1;
    flush.valid  = 1'b1;
    flush.pc     = 32'h0000_0100;
    exp_flush++;
    exp_q.push_back(32'h0000_0100);
    settle();
    chk("fl_acc_rsp_ready", {31'd0, ic_rsp_ready}, 32'd1);
    chk("fl_acc_pd_valid",  {31'd0, pd_valid}, 32'd0);
    step();
    flush        = '0;
    ic_rsp_valid = 1'b0;
    settle();
    check_req("req_fl_acc");
    step();

    // Zero advance re-fetches the same address.
    ic_rsp_valid  = 1'b1;
    pc_inc_amount = 5'd0;
    exp_q.push_back(32'h0000_0100);
    settle();
    chk("inc0_pd_valid", {31'd0, pd_valid}, 32'd1);
    step();
    ic_rsp_valid = 1'b0;
    settle();
    check_req("req_inc0");
    step();

    // 31 saturates to 16.
    ic_rsp_valid  = 1'b1;
    pc_inc_amount = 5'd31;
    exp_q.push_back(32'h0000_0110);
    step();
    ic_rsp_valid = 1'b0;
    settle();
    check_req("req_inc31");
    step();

    // Odd flush target is aligned; then +16 wraps past 2^32.
    flush.valid = 1'b1;
    flush.pc    = 32'hFFFF_FFF9;
    exp_flush++;
    step();
    flush         = '0;
    ic_rsp_valid  = 1'b1;
    exp_q.push_back(32'hFFFF_FFF8);
    step();
    ic_rsp_valid = 1'b0;
    settle();
    check_req("req_align");
    step();
    ic_rsp_valid  = 1'b1;
    pc_inc_amount = 5'd16;
    exp_q.push_back(32'h0000_0008);
    step();
    ic_rsp_valid = 1'b0;
    settle();
    check_req("req_wrap");
    step();

    // clk_en low for five cycles mid-WAIT: no handshakes, nothing moves.
    clk_en        = 1'b0;
    ic_rsp_valid  = 1'b1;
    stall         = 1'b1;
    pc_inc_amount = 5'd2;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("cen_req_valid", {31'd0, ic_req_valid}, 32'd0);
      chk("cen_rsp_ready", {31'd0, ic_rsp_ready}, 32'd0);
      chk("cen_pd_valid",  {31'd0, pd_valid}, 32'd0);
      chk("cen_pd_pc",     pd_pc, 32'h0000_0008);
      step();
    end
    clk_en = 1'b1;
    stall  = 1'b0;
    exp_q.push_back(32'h0000_000A);
    settle();
    chk("cen_resume_pd_valid", {31'd0, pd_valid}, 32'd1);
    chk("cen_resume_pd_pc",    pd_pc, 32'h0000_0008);
    step();
    ic_rsp_valid = 1'b0;
    settle();
    check_req("req_cen");
    step();

`ifdef FETCH_SEQ_PERF_EN
    chk("perf_stall", perf_stall_cnt, 32'(exp_stall));
    chk("perf_flush", perf_flush_cnt, 32'(exp_flush));
`else
    chk("perf_stall_off", perf_stall_cnt, 32'd0);
    chk("perf_flush_off", perf_flush_cnt, 32'd0);
`endif
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
